// File: rtl/phase_seq_monitor.sv
// Qualifies the one-hot four-phase ring stream: lock detection, rotation counting,
// per-error pulses and a sticky fault after repeated sequence errors.
module phase_seq_monitor #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned ERR_MAX  = 3,
  parameter int unsigned CYC_W    = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [3:0]       phase_in,
  input  logic             ack_fault,
  output logic             locked,
  output logic             err_pulse,
  output logic             fault,
  output logic [3:0]       err_count,
  output logic [CYC_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {StHunt, StAcq, StLock, StFault} state_e;

  localparam logic [3:0]       LockLast = 4'(LOCK_CNT - 1);
  localparam logic [3:0]       ErrLimit = 4'(ERR_MAX);
  localparam logic [CYC_W-1:0] CycMax   = {CYC_W{1'b1}};

  state_e           state_q, state_d;
  logic [3:0]       q_q, p_q;
  logic [3:0]       good_q, good_d;
  logic [3:0]       err_q, err_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             pulse_q, pulse_d;
  logic             step_ok;

  // q holds the newest word, p the one before it; a legal step rotates right by one.
  assign step_ok = $onehot(p_q) && $onehot(q_q) && (q_q == {p_q[0], p_q[3:1]});

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_d   = err_q;
    cyc_d   = cyc_q;
    pulse_d = 1'b0;
    unique case (state_q)
      StHunt: begin
        if ($onehot(q_q)) begin
          state_d = StAcq;
          good_d  = 4'd0;
        end
      end
      StAcq: begin
        if (!step_ok) begin
          state_d = StHunt;
          good_d  = 4'd0;
        end else if (good_q == LockLast) begin
          state_d = StLock;
          good_d  = 4'd0;
        end else begin
          good_d = good_q + 4'd1;
        end
      end
      StLock: begin
        if (step_ok) begin
          if (q_q == 4'b0001 && cyc_q != CycMax) begin
            cyc_d = cyc_q + 1'b1;
          end
        end else begin
          pulse_d = 1'b1;
          err_d   = err_q + 4'd1;
          state_d = (err_d == ErrLimit) ? StFault : StHunt;
        end
      end
      StFault: begin
        if (ack_fault) begin
          state_d = StHunt;
          err_d   = 4'd0;
        end
      end
      default: state_d = StHunt;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StHunt;
      q_q     <= 4'd0;
      p_q     <= 4'd0;
      good_q  <= 4'd0;
      err_q   <= 4'd0;
      cyc_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= phase_in;
      p_q     <= q_q;
      good_q  <= good_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      pulse_q <= pulse_d;
    end
  end

  assign locked    = (state_q == StLock);
  assign fault     = (state_q == StFault);
  assign err_pulse = pulse_q;
  assign err_count = err_q;
  assign cycle_cnt = cyc_q;

endmodule

// File: tb/tb_phase_seq_monitor.sv
// Directed bench for phase_seq_monitor with CYC_W = 4 so that rotation-count
// saturation is reachable in a short run.
module tb_phase_seq_monitor;

  logic       clk;
  logic       clr;
  logic [3:0] phase_in;
  logic       ack_fault;
  logic       locked;
  logic       err_pulse;
  logic       fault;
  logic [3:0] err_count;
  logic [3:0] cycle_cnt;

  int checks = 0;
  int errors = 0;
  int idx = 0;
  logic [3:0] rot [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

  phase_seq_monitor #(
    .LOCK_CNT(4),
    .ERR_MAX (3),
    .CYC_W   (4)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .phase_in (phase_in),
    .ack_fault(ack_fault),
    .locked   (locked),
    .err_pulse(err_pulse),
    .fault    (fault),
    .err_count(err_count),
    .cycle_cnt(cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input logic [3:0] ph);
    phase_in = ph;
    @(posedge clk);
    #1;
  endtask

  task automatic rot_step();
    tick(rot[idx]);
    idx = (idx + 1) % 4;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic l, input logic ep, input logic f,
                         input logic [3:0] ec, input logic [3:0] cc);
    chk({tag, ".locked"}, 32'(locked), 32'(l));
    chk({tag, ".err_pulse"}, 32'(err_pulse), 32'(ep));
    chk({tag, ".fault"}, 32'(fault), 32'(f));
    chk({tag, ".err_count"}, 32'(err_count), 32'(ec));
    chk({tag, ".cycle_cnt"}, 32'(cycle_cnt), 32'(cc));
  endtask

  initial begin
    clr       = 1'b0;
    ack_fault = 1'b0;
    phase_in  = 4'd0;

    // Reset held with random input
    repeat (3) tick(4'($urandom));
    chk_all("rst_hold", 0, 0, 0, 4'd0, 4'd0);
    clr = 1'b1;
    repeat (3) tick(4'b0000);
    chk_all("hunt_zero", 0, 0, 0, 4'd0, 4'd0);

    // Clean lock: locked after edge 6, first rotation counted at edge 9
    for (int k = 1; k <= 13; k++) begin
      rot_step();
      chk($sformatf("lock_e%0d.locked", k), 32'(locked), 32'(k >= 6));
      chk($sformatf("lock_e%0d.err_pulse", k), 32'(err_pulse), 32'd0);
      chk($sformatf("lock_e%0d.cycle", k), 32'(cycle_cnt), (k >= 9) ? 32'((k - 5) / 4) : 32'd0);
    end

    // Single glitch replacing 0100
    tick(4'b0110);
    idx = (idx + 1) % 4;
    chk("glitch_in_q.locked", 32'(locked), 32'd1);
    chk("glitch_in_q.err_pulse", 32'(err_pulse), 32'd0);
    for (int j = 1; j <= 7; j++) begin
      rot_step();
      if (j == 1) chk_all("glitch_det", 0, 1, 0, 4'd1, 4'd2);
      if (j == 2) chk("glitch_pulse_end", 32'(err_pulse), 32'd0);
      if (j == 5) chk("glitch_relock_early", 32'(locked), 32'd0);
      if (j == 6) chk_all("glitch_relock", 1, 0, 0, 4'd1, 4'd2);
      if (j == 7) chk("glitch_count_resume", 32'(cycle_cnt), 32'd3);
    end

    // ack_fault outside FAULT has no effect
    ack_fault = 1'b1;
    rot_step();
    ack_fault = 1'b0;
    chk_all("ack_ignored", 1, 0, 0, 4'd1, 4'd3);

    // Asynchronous reset mid-LOCK
    clr = 1'b0;
    #2;
    chk_all("async_clr", 0, 0, 0, 4'd0, 4'd0);
    repeat (2) tick(4'($urandom));
    chk_all("async_clr_hold", 0, 0, 0, 4'd0, 4'd0);
    clr = 1'b1;
    idx = 0;
    for (int k = 1; k <= 6; k++) begin
      rot_step();
      if (k == 5) chk("relock2_early", 32'(locked), 32'd0);
    end
    chk_all("relock2", 1, 0, 0, 4'd0, 4'd0);

    // Hold error
    rot_step();
    tick(4'b0010);
    rot_step();
    chk_all("hold_err", 0, 1, 0, 4'd1, 4'd0);
    for (int j = 1; j <= 5; j++) begin
      rot_step();
      if (j == 1) chk("hold_pulse_end", 32'(err_pulse), 32'd0);
      if (j == 4) chk("hold_relock_early", 32'(locked), 32'd0);
    end
    chk("hold_relock", 32'(locked), 32'd1);

    // Skip error: 1000 -> 0010
    tick(4'b0010);
    idx = 3;
    rot_step();
    chk_all("skip_err", 0, 1, 0, 4'd2, 4'd0);
    for (int j = 1; j <= 5; j++) rot_step();
    chk("skip_relock", 32'(locked), 32'd1);

    // Reversal error: 0100 -> 1000, third error enters FAULT
    rot_step();
    tick(4'b1000);
    idx = 1;
    rot_step();
    chk_all("rev_fault", 0, 1, 1, 4'd3, 4'd0);

    // FAULT ignores a clean sequence
    for (int j = 1; j <= 20; j++) begin
      rot_step();
      chk($sformatf("fault_hold%0d.fault", j), 32'(fault), 32'd1);
      chk($sformatf("fault_hold%0d.locked", j), 32'(locked), 32'd0);
    end
    chk_all("fault_hold_end", 0, 0, 1, 4'd3, 4'd0);

    // Acknowledge, then relock
    ack_fault = 1'b1;
    rot_step();
    ack_fault = 1'b0;
    chk_all("ack", 0, 0, 0, 4'd0, 4'd0);
    for (int j = 1; j <= 5; j++) begin
      rot_step();
      if (j == 4) chk("ack_relock_early", 32'(locked), 32'd0);
    end
    chk_all("ack_relock", 1, 0, 0, 4'd0, 4'd0);

    // Rotation counting and saturation at 15
    repeat (8) rot_step();
    chk("sat_partial", 32'(cycle_cnt), 32'd2);
    repeat (72) rot_step();
    chk("sat_reach", 32'(cycle_cnt), 32'd15);
    repeat (8) rot_step();
    chk_all("sat_hold", 1, 0, 0, 4'd0, 4'd15);

    // Reset mid-LOCK clears without a clock edge
    clr = 1'b0;
    #2;
    chk_all("mid_clr", 0, 0, 0, 4'd0, 4'd0);
    tick(4'($urandom));
    chk_all("mid_clr_hold", 0, 0, 0, 4'd0, 4'd0);
    clr = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_seq_monitor.md
# phase_seq_monitor

Checks the 4-bit one-hot phase stream produced by the four-phase ring signal generator. It sits directly downstream of that generator and confirms that every clock carries a legal rotation step: 1000 → 0100 → 0010 → 0001 → 1000. It reports lock status, counts completed rotations, pulses on each sequence error and latches a sticky fault after repeated errors. A supervisor uses it to qualify the generator output before enabling the phase drivers.

## Interface
- LOCK_CNT, default 4: consecutive legal steps required in ACQ to declare lock; legal range 1..15.
- ERR_MAX, default 3: errors in LOCK that trigger FAULT; legal range 1..15.
- CYC_W, default 8: width of the rotation counter.
- clk  in  1  clock; all state changes on the rising edge.
- clr  in  1  reset, asynchronous, active-low.
- phase_in  in  4  phase word from the generator; a new step is expected every clk.
- ack_fault  in  1  clears FAULT; sampled on clk.
- locked  out  1  high while the state is LOCK.
- err_pulse  out  1  one-cycle pulse per error detected in LOCK.
- fault  out  1  sticky; high while the state is FAULT.
- err_count  out  4  errors accumulated since reset or the last ack.
- cycle_cnt  out  CYC_W  completed rotations seen in LOCK; saturating.

## Operation
- Input pipeline:
  - q <= phase_in every edge.
  - p <= q every edge.
  - All checks use the registered q and p only.
- Definitions:
  - onehot(x): exactly one bit of x is set.
  - rotr(x): {x[0], x[3:1]}.
  - step_ok: onehot(p), onehot(q) and q == rotr(p).
- Illegal steps: 0000, multi-hot, hold (q == p), skip and reversal all make step_ok = 0.
- State machine (registered outputs):
  - HUNT: onehot(q) → ACQ and good_cnt = 0; otherwise stay.
  - ACQ, step_ok with good_cnt == LOCK_CNT-1 → LOCK.
  - ACQ, step_ok otherwise → good_cnt + 1.
  - ACQ, !step_ok → HUNT and good_cnt = 0. No err_pulse; err_count unchanged.
  - LOCK, step_ok: stay. If q == 0001, cycle_cnt + 1, saturating at 2^CYC_W-1.
  - LOCK, !step_ok: err_pulse = 1 next cycle and err_count + 1. If the new count == ERR_MAX → FAULT, else → HUNT.
  - FAULT: input ignored. ack_fault = 1 → HUNT and err_count = 0.
- ack_fault outside FAULT is ignored.
- cycle_cnt is kept across loss of lock and across FAULT; only clr clears it.
- Reset (clr = 0, any time, including mid-operation):
  - state = HUNT.
  - q, p, good_cnt = 0.
  - locked, err_pulse, fault = 0.
  - err_count, cycle_cnt = 0.
  - Held while clr is low; normal operation resumes on the first edge after release.

## Timing
- Input-to-decision latency: a value on phase_in before edge n is in q after edge n and in p after edge n+1.
- Lock latency: with a clean sequence valid from edge 1:
  - edge 2: HUNT → ACQ.
  - edges 3..2+LOCK_CNT: the LOCK_CNT step checks.
  - locked = 1 after edge 2+LOCK_CNT (edge 6 for the default).
- Error detection: a bad word before edge m is in q after edge m. At edge m+1:
  - err_pulse goes high for exactly one cycle.
  - locked drops.
  - err_count and state update in the same edge.
- Rotation count: cycle_cnt updates on the same edge as the step check that sees q == 0001.
- Relock after an error: if the first onehot q is evaluated at edge m+2, locked returns LOCK_CNT+1 edges after that HUNT evaluation (HUNT → ACQ, then LOCK_CNT checks).
- Priority when events coincide:
  - clr overrides everything.
  - In FAULT, ack_fault is the only event acted on.
  - In LOCK, an error at the step that reaches ERR_MAX goes to FAULT, never to HUNT.

## Test plan
- Reset: hold clr = 0 with random phase_in → all outputs 0. Release and drive 0000 → state stays HUNT, locked = 0.
- Clean lock: drive the rotation from edge 1 with the defaults → locked rises after edge 6. cycle_cnt increments once every 4 cycles, err_pulse stays 0.
- Single glitch: in LOCK, insert 0110 for one cycle → err_pulse high for exactly 1 cycle, locked falls, err_count = 1. The clean sequence relocks, then rotation counting resumes.
- Bad steps: in LOCK, inject a hold (0100, 0100), a skip (1000 → 0010) and a reversal (0100 → 1000) → each produces one err_pulse. The third gives fault = 1 with err_count = 3.
- Fault handling: in FAULT, drive a clean sequence for 20 cycles → fault stays 1, locked stays 0. Pulse ack_fault once → fault = 0, err_count = 0, then relock.
- Saturation and mid-reset: with CYC_W = 4, run 20 rotations → cycle_cnt = 15 and holds. Assert clr mid-LOCK → all outputs 0 immediately, without waiting for a clk edge.
